// File: rtl/prog_loader.sv
// Byte-stream program loader: length, little-endian data words, checksum.
// Writes instruction memory from word 0 and releases core reset on a good image.
module prog_loader #(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;

  logic              xfer_c;
  logic              byte_last_c;
  logic              last_word_c;
  logic [31:0]       len_full_c;
  logic [31:0]       word_full_c;

  // Bytes arrive LSB first, so shifting in from the top assembles little-endian values.
  assign xfer_c      = in_valid & in_ready;
  assign byte_last_c = (byte_idx_q == 2'd3);
  assign len_full_c  = {in_data, len_q[31:8]};
  assign word_full_c = {in_data, word_q[31:8]};
  assign last_word_c = ((32'(word_cnt_q) + 32'd1) == len_q);

  assign in_ready = !rst && ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: begin
        if (xfer_c && byte_last_c) begin
          if (len_full_c > MAX_LEN) begin
            state_d = S_ERR;
          end else if (len_full_c == 32'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c && byte_last_c && last_word_c) begin
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (xfer_c) begin
          state_d = (in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    byte_idx_d  = byte_idx_q;
    len_d       = len_q;
    word_d      = word_q;
    csum_d      = csum_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_LEN: begin
        if (xfer_c) begin
          len_d      = len_full_c;
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          word_d     = word_full_c;
          byte_idx_d = byte_idx_q + 2'd1;
          csum_d     = csum_q + in_data;
          if (byte_last_c) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = word_full_c;
            word_cnt_d  = word_cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Terminal states make these sticky without extra hold logic.
    load_done_d = (state_d == S_DONE);
    load_err_d  = (state_d == S_ERR);
    core_rst_d  = (state_d != S_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q  <= 2'd0;
      len_q       <= 32'd0;
      word_q      <= 32'd0;
      csum_q      <= 8'd0;
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      core_rst_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      len_q       <= len_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      word_cnt_q  <= word_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_rst_q  <= core_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_rst  = core_rst_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal, checksum/length errors, throttling,
// mid-load reset and full-depth image.
`timescale 1ns/1ps
module tb_prog_loader;

  localparam int unsigned ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_cnt;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int                wr_cnt  = 0;
  int                seq_err = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_data = 32'd0;
  logic [31:0]       exp_q[$];
  logic [31:0]       img_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must hit the next sequential address with the next expected word.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        seq_err++;
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (mem_wdata !== e || mem_addr !== ADDR_W'(wr_cnt)) seq_err++;
      end
      last_addr = mem_addr;
      last_data = mem_wdata;
      wr_cnt++;
    end
  end

  task automatic clear_log();
    wr_cnt  = 0;
    seq_err = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_rst_in_ready"},  32'(in_ready),  32'd0);
    check_eq({tag, "_rst_mem_we"},    32'(mem_we),    32'd0);
    check_eq({tag, "_rst_mem_addr"},  32'(mem_addr),  32'd0);
    check_eq({tag, "_rst_mem_wdata"}, mem_wdata,      32'd0);
    check_eq({tag, "_rst_word_cnt"},  32'(word_cnt),  32'd0);
    check_eq({tag, "_rst_core_rst"},  32'(core_rst),  32'd1);
    check_eq({tag, "_rst_load_done"}, 32'(load_done), 32'd0);
    check_eq({tag, "_rst_load_err"},  32'(load_err),  32'd0);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int t;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic send_image(input logic [31:0] n, input logic [7:0] csum, input int gap_max);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap_max);
    foreach (img_q[k]) begin
      w = img_q[k];
      exp_q.push_back(w);
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], gap_max);
    end
    send_byte(csum, gap_max);
    @(negedge clk);
  endtask

  task automatic load_t1_image();
    img_q.delete();
    img_q.push_back(32'h0000_0013);
    img_q.push_back(32'hDEAD_BEEF);
  endtask

  task automatic check_t1_ok(input string tag);
    check_eq({tag, "_wr_cnt"},    32'(wr_cnt),    32'd2);
    check_eq({tag, "_seq_err"},   32'(seq_err),   32'd0);
    check_eq({tag, "_last_addr"}, 32'(last_addr), 32'd1);
    check_eq({tag, "_last_data"}, last_data,      32'hDEAD_BEEF);
    check_eq({tag, "_load_done"}, 32'(load_done), 32'd1);
    check_eq({tag, "_load_err"},  32'(load_err),  32'd0);
    check_eq({tag, "_core_rst"},  32'(core_rst),  32'd0);
    check_eq({tag, "_word_cnt"},  32'(word_cnt),  32'd2);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;

    // T1 nominal two-word image, checksum 0x4B
    do_reset("t1");
    load_t1_image();
    send_image(32'd2, 8'h4B, 0);
    check_t1_ok("t1");

    // T2 bad checksum: writes still happen, core held
    do_reset("t2");
    load_t1_image();
    send_image(32'd2, 8'h4C, 0);
    check_eq("t2_wr_cnt",    32'(wr_cnt),    32'd2);
    check_eq("t2_seq_err",   32'(seq_err),   32'd0);
    check_eq("t2_load_err",  32'(load_err),  32'd1);
    check_eq("t2_load_done", 32'(load_done), 32'd0);
    check_eq("t2_core_rst",  32'(core_rst),  32'd1);
    check_eq("t2_in_ready",  32'(in_ready),  32'd0);

    // T3 empty image, good and bad checksum
    do_reset("t3a");
    img_q.delete();
    send_image(32'd0, 8'h00, 0);
    check_eq("t3a_wr_cnt",    32'(wr_cnt),    32'd0);
    check_eq("t3a_load_done", 32'(load_done), 32'd1);
    check_eq("t3a_core_rst",  32'(core_rst),  32'd0);
    do_reset("t3b");
    img_q.delete();
    send_image(32'd0, 8'h01, 0);
    check_eq("t3b_load_err",  32'(load_err),  32'd1);
    check_eq("t3b_load_done", 32'(load_done), 32'd0);

    // T4 oversize length 0x2001
    do_reset("t4");
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check_eq("t4_load_err", 32'(load_err), 32'd1);
    check_eq("t4_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    check_eq("t4_wr_cnt",   32'(wr_cnt),   32'd0);
    check_eq("t4_core_rst", 32'(core_rst), 32'd1);

    // T5a throttled T1
    do_reset("t5a");
    load_t1_image();
    send_image(32'd2, 8'h4B, 3);
    check_t1_ok("t5a");

    // T5b reset after 6 data bytes, then replay
    do_reset("t5b");
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 1);
    send_byte(8'hBE, 1);
    @(negedge clk);
    check_eq("t5b_mid_word_cnt", 32'(word_cnt),  32'd1);
    check_eq("t5b_mid_load_done", 32'(load_done), 32'd0);
    do_reset("t5c");
    load_t1_image();
    send_image(32'd2, 8'h4B, 1);
    check_t1_ok("t5c");

    // T6 full depth: word i = i; low bytes sum 32*(0..255), high bytes 256*(0..31) -> checksum 0x00
    do_reset("t6");
    img_q.delete();
    for (int i = 0; i < 8192; i++) img_q.push_back(32'(i));
    send_image(32'd8192, 8'h00, 0);
    check_eq("t6_wr_cnt",    32'(wr_cnt),    32'd8192);
    check_eq("t6_seq_err",   32'(seq_err),   32'd0);
    check_eq("t6_last_addr", 32'(last_addr), 32'h0000_1FFF);
    check_eq("t6_last_data", last_data,      32'h0000_1FFF);
    check_eq("t6_word_cnt",  32'(word_cnt),  32'd8192);
    check_eq("t6_load_done", 32'(load_done), 32'd1);
    check_eq("t6_core_rst",  32'(core_rst),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
